imdct_window_sequencer: RTL and testbench

//  Sequences the IMDCT sine-window coefficient ROM for one 36-sample IMDCT output block.

---
 rtl/imdct_window_sequencer_if.sv | 33 +++
 rtl/imdct_window_sequencer.sv | 141 ++++++++++++++
 tb/tb_imdct_window_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imdct_window_sequencer_if.sv
// Signal bundle between the IMDCT window sequencer, the sample buffer / window ROM,
// and the overlap-add stage.
interface imdct_window_sequencer_if #(
   parameter int DATA_W = 18
);
   logic              start;
   logic [1:0]        window;
   logic              busy;
   logic              done;
   logic              rom_enable;
   logic [1:0]        rom_window;
   logic [5:0]        rom_n;
   logic [DATA_W-1:0] rom_data;
   logic              smp_rd;
   logic [5:0]        smp_addr;
   logic [DATA_W-1:0] smp_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [5:0]        out_idx;

   modport slave (
      input  start, window, rom_data, smp_data, out_ready,
      output busy, done, rom_enable, rom_window, rom_n, smp_rd, smp_addr,
             out_valid, out_data, out_idx
   );

   modport master (
      output start, window, rom_data, smp_data, out_ready,
      input  busy, done, rom_enable, rom_window, rom_n, smp_rd, smp_addr,
             out_valid, out_data, out_idx
   );
endinterface

// File: rtl/imdct_window_sequencer.sv
// Walks one 36-sample IMDCT block, fetching sample + window coefficient per index,
// multiplies them and streams the windowed result in order through a 2-entry FIFO.
module imdct_window_sequencer #(
   parameter int DATA_W  = 18,
   parameter int LONG_N  = 36,
   parameter int SHORT_N = 12,
   parameter int SHORT_K = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   imdct_window_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam logic [5:0]        LAST_I = 6'(LONG_N - 1);
   localparam logic [5:0]        LAST_M = 6'(SHORT_N - 1);
   localparam logic [DATA_W-1:0] S_MAX  = {1'b0, {(DATA_W-1){1'b1}}};

   if (SHORT_N * SHORT_K != LONG_N) begin : g_param_check
      $error("SHORT_N*SHORT_K must equal LONG_N");
   end

   state_t            state_q, state_d;
   logic [1:0]        win_q, win_d;
   logic [5:0]        i_q, i_d;
   logic [5:0]        m_q, m_d;
   logic [5:0]        rom_n_q, smp_addr_q;
   logic              dv_q;
   logic [5:0]        dv_idx_q;
   logic [DATA_W-1:0] fd_q [2];
   logic [5:0]        fi_q [2];
   logic              rp_q, wp_q;
   logic [1:0]        cnt_q;

   logic              issue, pop, done_c;
   logic [2:0]        occ;
   logic [5:0]        n_addr;

   // Occupancy after this cycle's write and pop; one more read fits while it is below 2.
   assign pop    = (cnt_q != 2'd0) && bus.out_ready;
   assign occ    = 3'(cnt_q) + 3'(dv_q) - 3'(pop);
   assign n_addr = (win_q == 2'd2) ? m_q : i_q;

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      i_d     = i_q;
      m_d     = m_q;
      issue   = 1'b0;
      done_c  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
               win_d   = bus.window;
               i_d     = '0;
               m_d     = '0;
            end
         end
         RUN: begin
            if (occ < 3'd2) begin
               issue = 1'b1;
               if (i_q == LAST_I) begin
                  state_d = DRAIN;
               end else begin
                  i_d = i_q + 6'd1;
                  m_d = (m_q == LAST_M) ? 6'd0 : m_q + 6'd1;
               end
            end
         end
         DRAIN: begin
            if (occ == 3'd0) begin
               done_c  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Full-precision product; only +2^(2*DATA_W-2) can overflow the output slice.
   logic signed [2*DATA_W-1:0] prod;
   logic                       sat;
   logic [DATA_W-1:0]          wdat;
   logic                       unused_lsbs;

   assign prod        = $signed(bus.smp_data) * $signed(bus.rom_data);
   assign sat         = prod[2*DATA_W-1] != prod[2*DATA_W-2];
   assign wdat        = sat ? S_MAX : prod[2*DATA_W-2 -: DATA_W];
   assign unused_lsbs = ^prod[DATA_W-2:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         win_q      <= '0;
         i_q        <= '0;
         m_q        <= '0;
         rom_n_q    <= '0;
         smp_addr_q <= '0;
         dv_q       <= 1'b0;
         dv_idx_q   <= '0;
         rp_q       <= 1'b0;
         wp_q       <= 1'b0;
         cnt_q      <= '0;
         for (int k = 0; k < 2; k++) begin
            fd_q[k] <= '0;
            fi_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         i_q     <= i_d;
         m_q     <= m_d;
         dv_q    <= issue;
         if (issue) begin
            rom_n_q    <= n_addr;
            smp_addr_q <= i_q;
            dv_idx_q   <= i_q;
         end
         if (dv_q) begin
            fd_q[wp_q] <= wdat;
            fi_q[wp_q] <= dv_idx_q;
            wp_q       <= ~wp_q;
         end
         if (pop) rp_q <= ~rp_q;
         cnt_q <= occ[1:0];
      end
   end

   // Address outputs show the live index while reading, otherwise the last one issued.
   assign bus.rom_enable = issue;
   assign bus.smp_rd     = issue;
   assign bus.rom_window = win_q;
   assign bus.rom_n      = issue ? n_addr : rom_n_q;
   assign bus.smp_addr   = issue ? i_q : smp_addr_q;
   assign bus.busy       = state_q != IDLE;
   assign bus.done       = done_c;
   assign bus.out_valid  = cnt_q != 2'd0;
   assign bus.out_data   = fd_q[rp_q];
   assign bus.out_idx    = fi_q[rp_q];
endmodule

// File: tb/tb_imdct_window_sequencer.sv
// Bench for imdct_window_sequencer: memory models, an arithmetic reference model,
// a fixed vector table and hand-built corner sequences.
module tb_imdct_window_sequencer;
   localparam int DW = 18;

   typedef struct { logic [17:0] smp; logic [17:0] coef; logic [17:0] exp; } vec_t;
   typedef struct { logic [17:0] d; logic [5:0] idx; } out_t;
   typedef struct { logic [1:0] w; logic [5:0] n; logic [5:0] a; } rd_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   imdct_window_sequencer_if #(.DATA_W(DW)) bus ();
   imdct_window_sequencer #(.DATA_W(DW), .LONG_N(36), .SHORT_N(12), .SHORT_K(3)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   logic [17:0] smp_mem [64];
   logic [17:0] rom_mem [4][64];
   vec_t        tbl [11];
   out_t        exp_q [$];
   rd_t         addr_q [$];
   logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   int nvec = 0, nerr = 0, cyc = 0;
   int t_start, first_cyc, done_cyc, nout, ndone, issued, accepted;
   int rdy_mode = 0, pidx = 0;
   bit mon_en = 1'b0, prev_stall = 1'b0;
   logic [17:0] prev_d;
   logic [5:0]  prev_i;

   always @(posedge clk) cyc <= cyc + 1;

   // One-cycle-latency sample buffer and window ROM
   always @(posedge clk) begin
      if (bus.rom_enable) bus.rom_data <= rom_mem[bus.rom_window][bus.rom_n];
      if (bus.smp_rd)     bus.smp_data <= smp_mem[bus.smp_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Q1.17 window multiply: floor(s*c / 2^17), clamped to the signed 18-bit range
   function automatic logic [17:0] ref_mul(input logic [17:0] s, input logic [17:0] c);
      longint p, q;
      p = longint'($signed(s)) * longint'($signed(c));
      q = p >>> 17;
      if (q > 131071)  q = 131071;
      if (q < -131072) q = -131072;
      return q[17:0];
   endfunction

   function automatic void build_model(input logic [1:0] w);
      for (int k = 0; k < 36; k++) begin
         logic [5:0] n;
         n = (w == 2'd2) ? 6'(k % 12) : 6'(k);
         exp_q.push_back('{ref_mul(smp_mem[k], rom_mem[w][n]), 6'(k)});
         addr_q.push_back('{w, n, 6'(k)});
      end
   endfunction

   task automatic clear_mon();
      exp_q.delete();
      addr_q.delete();
      issued = 0; accepted = 0; nout = 0; ndone = 0;
      first_cyc = -1; done_cyc = -1; prev_stall = 1'b0;
      mon_en = 1'b1;
   endtask

   task automatic fill_rand();
      for (int k = 0; k < 64; k++) begin
         smp_mem[k] = ($urandom_range(0, 9) == 0) ? 18'h20000 : 18'($urandom);
         for (int w = 0; w < 4; w++)
            rom_mem[w][k] = ($urandom_range(0, 9) == 0) ? 18'h20000 : 18'($urandom);
      end
   endtask

   // Drives out_ready for the coming edge, then checks the settled outputs of this cycle
   always @(negedge clk) begin
      if (rdy_mode == 0)      bus.out_ready = 1'b1;
      else if (rdy_mode == 1) begin bus.out_ready = pat[pidx]; pidx = (pidx + 1) % 4; end
      else                    bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      if (mon_en) begin
         if (bus.rom_enable) begin
            rd_t r;
            issued++;
            chk("smp_rd with rom_enable", 32'(bus.smp_rd), 32'd1);
            chk("read expected", 32'(addr_q.size() != 0), 32'd1);
            if (addr_q.size() != 0) begin
               r = addr_q.pop_front();
               chk("rom_window", 32'(bus.rom_window), 32'(r.w));
               chk("rom_n", 32'(bus.rom_n), 32'(r.n));
               chk("smp_addr", 32'(bus.smp_addr), 32'(r.a));
            end
         end
         if (prev_stall)
            chk("held while stalled", {bus.out_valid, bus.out_data, bus.out_idx}, {1'b1, prev_d, prev_i});
         if (bus.out_valid && bus.out_ready) begin
            out_t o;
            accepted++;
            if (nout == 0) first_cyc = cyc;
            nout++;
            chk("output expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               o = exp_q.pop_front();
               chk("out_idx", 32'(bus.out_idx), 32'(o.idx));
               chk("out_data", 32'(bus.out_data), 32'(o.d));
            end
         end
         if (bus.rom_enable || bus.out_valid)
            chk("outstanding <= 2", 32'((issued - accepted) <= 2), 32'd1);
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_d     = bus.out_data;
         prev_i     = bus.out_idx;
         if (bus.done) begin ndone++; done_cyc = cyc; end
      end
   end

   task automatic wait_done(input int budget);
      int k = 0;
      while (ndone == 0 && k < budget) begin @(negedge clk); k++; end
      chk("done within budget", 32'(ndone != 0), 32'd1);
      repeat (3) @(negedge clk);
      #2;
      chk("outputs per block", 32'(nout), 32'd36);
      chk("done pulses", 32'(ndone), 32'd1);
      chk("outputs left unseen", 32'(exp_q.size()), 32'd0);
      chk("reads left unseen", 32'(addr_q.size()), 32'd0);
      chk("busy after done", 32'(bus.busy), 32'd0);
   endtask

   task automatic run_block(input logic [1:0] w);
      @(negedge clk);
      bus.window = w; bus.start = 1'b1; t_start = cyc;
      @(negedge clk);
      bus.start = 1'b0;
      #2;
      chk("busy after start", 32'(bus.busy), 32'd1);
      wait_done(400);
   endtask

   initial begin
      int k;
      bit hit, any;
      tbl[0]  = '{18'h10000, 18'h10000, 18'h08000};
      tbl[1]  = '{18'h20000, 18'h20000, 18'h1FFFF};
      tbl[2]  = '{18'h3FFFF, 18'h00001, 18'h3FFFF};
      tbl[3]  = '{18'h00001, 18'h00001, 18'h00000};
      tbl[4]  = '{18'h1FFFF, 18'h1FFFF, 18'h1FFFE};
      tbl[5]  = '{18'h20000, 18'h1FFFF, 18'h20001};
      tbl[6]  = '{18'h10000, 18'h30000, 18'h38000};
      tbl[7]  = '{18'h00003, 18'h20000, 18'h3FFFD};
      tbl[8]  = '{18'h20000, 18'h00000, 18'h00000};
      tbl[9]  = '{18'h00005, 18'h10000, 18'h00002};
      tbl[10] = '{18'h3FFFB, 18'h10000, 18'h3FFFD};
      bus.start = 1'b0; bus.window = 2'd0;

      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk); #2;
      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset done", 32'(bus.done), 32'd0);
      chk("reset rom_enable", 32'(bus.rom_enable), 32'd0);
      chk("reset smp_rd", 32'(bus.smp_rd), 32'd0);
      chk("reset rom_window", 32'(bus.rom_window), 32'd0);
      chk("reset rom_n", 32'(bus.rom_n), 32'd0);
      chk("reset smp_addr", 32'(bus.smp_addr), 32'd0);
      chk("reset out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset out_data", 32'(bus.out_data), 32'd0);
      chk("reset out_idx", 32'(bus.out_idx), 32'd0);

      // 0.5 x 0.5 long block at full rate
      clear_mon();
      for (int i = 0; i < 64; i++) begin smp_mem[i] = 18'h10000; rom_mem[0][i] = 18'h10000; end
      build_model(2'd0);
      rdy_mode = 0;
      run_block(2'd0);
      chk("first out_valid latency", 32'(first_cyc - t_start), 32'd3);
      chk("done cycle after start", 32'(done_cyc - t_start), 32'd38);

      // Short window: ROM returns its own address
      clear_mon();
      fill_rand();
      for (int i = 0; i < 64; i++) rom_mem[2][i] = {10'd0, 2'd2, 6'(i)};
      build_model(2'd2);
      run_block(2'd2);

      // Arithmetic vector table, random backpressure
      clear_mon();
      for (int i = 0; i < 36; i++) begin
         smp_mem[i]    = tbl[i % 11].smp;
         rom_mem[0][i] = tbl[i % 11].coef;
         exp_q.push_back('{tbl[i % 11].exp, 6'(i)});
         addr_q.push_back('{2'd0, 6'(i), 6'(i)});
      end
      rdy_mode = 2;
      run_block(2'd0);

      // Start window, ready pattern 1,0,0,1
      clear_mon();
      fill_rand();
      build_model(2'd1);
      rdy_mode = 1;
      run_block(2'd1);

      // start during RUN with another window is ignored
      clear_mon();
      fill_rand();
      build_model(2'd1);
      rdy_mode = 0;
      @(negedge clk);
      bus.window = 2'd1; bus.start = 1'b1; t_start = cyc;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      bus.window = 2'd3; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.window = 2'd0;
      wait_done(400);

      // Reset while output 17 is presented aborts the block
      clear_mon();
      fill_rand();
      build_model(2'd0);
      @(negedge clk);
      bus.window = 2'd0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      k = 0; hit = 1'b0;
      while (!hit && k < 100) begin
         @(negedge clk); #2;
         hit = bus.out_valid && (bus.out_idx == 6'd17);
         k++;
      end
      chk("reached idx 17", 32'(hit), 32'd1);
      reset = 1'b1; mon_en = 1'b0;
      @(negedge clk); #2;
      chk("abort busy", 32'(bus.busy), 32'd0);
      chk("abort out_valid", 32'(bus.out_valid), 32'd0);
      chk("abort done", 32'(bus.done), 32'd0);
      chk("abort rom_enable", 32'(bus.rom_enable), 32'd0);
      reset = 1'b0;
      any = 1'b0;
      repeat (6) begin
         @(negedge clk); #2;
         any = any | bus.done | bus.rom_enable | bus.out_valid;
      end
      chk("quiet after abort", 32'(any), 32'd0);
      clear_mon();
      build_model(2'd0);
      run_block(2'd0);

      // Random windows and data under random backpressure
      for (int r = 0; r < 4; r++) begin
         logic [1:0] w;
         w = 2'($urandom_range(0, 3));
         clear_mon();
         fill_rand();
         build_model(w);
         rdy_mode = 2;
         run_block(w);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
